// File: rtl/level_sequencer_pkg.sv
// Shared types and default timing constants for the level sequencer.
package vgaPkg;

  typedef enum logic [2:0] {
    TITLE = 3'd0,
    INTRO = 3'd1,
    PLAY  = 3'd2,
    CLEAR = 3'd3,
    DEATH = 3'd4,
    OVER  = 3'd5
  } state_t;

  // Default pause lengths, in frames, and starting life count
  localparam int INTRO_FRAMES_DEF = 120;
  localparam int CLEAR_FRAMES_DEF = 90;
  localparam int DEATH_FRAMES_DEF = 60;
  localparam int OVER_FRAMES_DEF  = 180;
  localparam int START_LIVES_DEF  = 3;

  // Overlay/enable bundle derived purely from the state
  typedef struct packed {
    logic start_game;
    logic freeze;
    logic show_title;
    logic show_over;
  } ovl_t;

  function automatic ovl_t decode_state(state_t s);
    ovl_t o;
    o.start_game = (s == INTRO) || (s == PLAY) || (s == CLEAR) || (s == DEATH);
    o.freeze     = (s != PLAY);
    o.show_title = (s == TITLE);
    o.show_over  = (s == OVER);
    return o;
  endfunction

endpackage

// File: rtl/level_sequencer_btn_edge.sv
// Two-flop synchronizer for the raw start button plus a rising-edge detector.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // Bring the button into the clock domain and remember the last synced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // One-cycle pulse when the synchronized level goes 0 -> 1
  assign press = sync2_reg & ~prev_reg;

endmodule

// File: rtl/level_sequencer.sv
// Game flow sequencer: title, intro, play, clear/death pauses, game over.
// Pauses are measured in frames, counted on the vsync-derived frame tick.
module level_sequencer
  import vgaPkg::*;
#(
  parameter int INTRO_FRAMES = INTRO_FRAMES_DEF,
  parameter int CLEAR_FRAMES = CLEAR_FRAMES_DEF,
  parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
  parameter int OVER_FRAMES  = OVER_FRAMES_DEF,
  parameter int START_LIVES  = START_LIVES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       vsync,
  input  logic       player_hit,
  input  logic       player_win,
  output logic       start_game,
  output logic       freeze,
  output logic [1:0] level,
  output logic [1:0] lives,
  output logic       show_title,
  output logic       show_over
);

  logic       press;
  logic       vsync_d_reg;
  logic       frame_tick_reg;
  state_t     state_reg, state_next;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic [1:0] level_next, lives_next;

  btn_edge u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (start_btn),
    .press (press)
  );

  // Frame tick: one-cycle pulse registered after a vsync rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d_reg    <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      vsync_d_reg    <= vsync;
      frame_tick_reg <= vsync & ~vsync_d_reg;
    end
  end

  // Next-state, frame counter, level and lives update rules
  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    level_next     = level;
    lives_next     = lives;
    case (state_reg)
      TITLE: begin
        if (press) begin
          state_next     = INTRO;
          frame_cnt_next = 8'd0;
          level_next     = 2'd0;
          lives_next     = 2'(START_LIVES);
        end
      end
      INTRO: begin
        if (frame_tick_reg) begin
          if (frame_cnt_reg == 8'(INTRO_FRAMES - 1)) begin
            state_next     = PLAY;
            frame_cnt_next = 8'd0;
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
      end
      PLAY: begin
        // A hit beats a simultaneous win
        if (player_hit) begin
          state_next     = DEATH;
          frame_cnt_next = 8'd0;
        end else if (player_win) begin
          state_next     = CLEAR;
          frame_cnt_next = 8'd0;
        end
      end
      CLEAR: begin
        if (frame_tick_reg) begin
          if (frame_cnt_reg == 8'(CLEAR_FRAMES - 1)) begin
            frame_cnt_next = 8'd0;
            if (level == 2'd3) begin
              state_next = TITLE;
            end else begin
              state_next = INTRO;
              level_next = level + 2'd1;
            end
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
      end
      DEATH: begin
        if (frame_tick_reg) begin
          if (frame_cnt_reg == 8'(DEATH_FRAMES - 1)) begin
            frame_cnt_next = 8'd0;
            lives_next     = lives - 2'd1;
            state_next     = (lives == 2'd1) ? OVER : INTRO;
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
      end
      OVER: begin
        if (frame_tick_reg) begin
          if (frame_cnt_reg == 8'(OVER_FRAMES - 1)) begin
            state_next     = TITLE;
            frame_cnt_next = 8'd0;
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next     = TITLE;
        frame_cnt_next = 8'd0;
      end
    endcase
  end

  // State register; outputs are decoded from the next state so they change together with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= TITLE;
      frame_cnt_reg <= 8'd0;
      level         <= 2'd0;
      lives         <= 2'd0;
      start_game    <= 1'b0;
      freeze        <= 1'b1;
      show_title    <= 1'b1;
      show_over     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= frame_cnt_next;
      level         <= level_next;
      lives         <= lives_next;
      {start_game, freeze, show_title, show_over} <= decode_state(state_next);
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: directed game flow with random
// vsync spacing and random ignored-input noise, checked against a frame-level model.
module tb_level_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       vsync;
  logic       player_hit;
  logic       player_win;
  logic       start_game;
  logic       freeze;
  logic [1:0] level;
  logic [1:0] lives;
  logic       show_title;
  logic       show_over;

  int checks   = 0;
  int failures = 0;

  level_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .vsync      (vsync),
    .player_hit (player_hit),
    .player_win (player_win),
    .start_game (start_game),
    .freeze     (freeze),
    .level      (level),
    .lives      (lives),
    .show_title (show_title),
    .show_over  (show_over)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (game-rule level) ----------------
  typedef enum int {P_TITLE, P_INTRO, P_PLAY, P_CLEAR, P_DEATH, P_OVER} phase_e;
  phase_e m_phase;
  int     m_level;
  int     m_lives;
  int     m_ticks;

  function automatic int pause_len(phase_e p);
    case (p)
      P_INTRO: return 120;
      P_CLEAR: return 90;
      P_DEATH: return 60;
      P_OVER:  return 180;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_phase = P_TITLE; m_level = 0; m_lives = 0; m_ticks = 0;
  endtask

  task automatic m_press();
    if (m_phase == P_TITLE) begin
      m_phase = P_INTRO; m_level = 0; m_lives = 3; m_ticks = 0;
    end
  endtask

  task automatic m_tick();
    if (pause_len(m_phase) != 0) begin
      m_ticks++;
      if (m_ticks == pause_len(m_phase)) begin
        m_ticks = 0;
        case (m_phase)
          P_INTRO: m_phase = P_PLAY;
          P_CLEAR: if (m_level == 3) m_phase = P_TITLE;
                   else begin m_level++; m_phase = P_INTRO; end
          P_DEATH: begin m_lives--; m_phase = (m_lives == 0) ? P_OVER : P_INTRO; end
          P_OVER:  m_phase = P_TITLE;
          default: ;
        endcase
      end
    end
  endtask

  task automatic m_event(input bit hit, input bit win);
    if (m_phase == P_PLAY) begin
      if (hit) begin m_phase = P_DEATH; m_ticks = 0; end
      else if (win) begin m_phase = P_CLEAR; m_ticks = 0; end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string ctx);
    chk({ctx, ".start_game"}, 8'(start_game), 8'(m_phase inside {P_INTRO, P_PLAY, P_CLEAR, P_DEATH}));
    chk({ctx, ".freeze"},     8'(freeze),     8'(m_phase != P_PLAY));
    chk({ctx, ".show_title"}, 8'(show_title), 8'(m_phase == P_TITLE));
    chk({ctx, ".show_over"},  8'(show_over),  8'(m_phase == P_OVER));
    chk({ctx, ".level"},      8'(level),      8'(m_level));
    chk({ctx, ".lives"},      8'(lives),      8'(m_lives));
    $display("txn %-12s phase=%s level=%0d lives=%0d ticks=%0d", ctx, m_phase.name(), m_level, m_lives, m_ticks);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Occasionally wiggle inputs that the current phase must ignore
  task automatic noise();
    if (m_phase != P_PLAY && $urandom_range(0, 3) == 0) begin
      if (m_phase != P_TITLE && $urandom_range(0, 1) == 1) begin
        start_btn = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        start_btn = 1'b0;
      end
      player_win = 1'($urandom_range(0, 1));
      player_hit = 1'($urandom_range(0, 1));
      step();
      player_win = 1'b0;
      player_hit = 1'b0;
      repeat (4) step();
      check_model("noise");
    end
  endtask

  // One vsync pulse: state must not move one edge after the rise, must move on the next
  task automatic do_tick();
    noise();
    vsync = 1'b1;
    step();
    check_model("tick_early");
    step();
    m_tick();
    check_model("tick");
    vsync = 1'b0;
    repeat ($urandom_range(1, 3)) step();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // Button press: two synchronizer edges of latency, then the transition edge
  task automatic do_press(input int hold);
    start_btn = 1'b1;
    step();
    check_model("press_sync1");
    step();
    check_model("press_sync2");
    step();
    m_press();
    check_model("press");
    repeat (hold) step();
    start_btn = 1'b0;
    repeat (3) step();
    check_model("press_held");
  endtask

  task automatic do_event(input bit hit, input bit win);
    player_hit = hit;
    player_win = win;
    step();
    m_event(hit, win);
    check_model("event");
    player_hit = 1'b0;
    player_win = 1'b0;
    step();
    check_model("event_after");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start_btn = 1'b0; vsync = 1'b0; player_hit = 1'b0; player_win = 1'b0;
    m_reset();
    repeat (2) step();
    check_model("reset");
    rst = 1'b0;
    step();
    check_model("post_reset");

    // Game 1: ignored flags in TITLE, long press, three deaths to game over
    do_event(1'b0, 1'b1);
    do_event(1'b1, 1'b0);
    do_press($urandom_range(20, 60));
    run_ticks(120);
    do_event(1'b1, 1'b1);
    run_ticks(60);
    do_event(1'b0, 1'b1);
    run_ticks(120);
    do_event(1'b1, 1'b0);
    run_ticks(60);
    run_ticks(120);
    do_event(1'b1, 1'($urandom_range(0, 1)));
    run_ticks(60);
    do_press(5);
    run_ticks(180);

    // Game 2: clear all four levels, level holds at 3 on the final clear
    do_press($urandom_range(1, 10));
    for (int lv = 0; lv < 4; lv++) begin
      run_ticks(120);
      do_event(1'b0, 1'b1);
      run_ticks(90);
    end

    // Game 3: reset in the middle of a level-clear pause
    do_press(2);
    run_ticks(120);
    do_event(1'b0, 1'b1);
    run_ticks(45);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    check_model("async_reset");
    repeat (3) step();
    rst = 1'b0;
    step();
    check_model("reset_release");
    do_press(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameters, each one per line: INTRO_FRAMES default 120, frames shown before play; CLEAR_FRAMES default 90, level-clear pause; DEATH_FRAMES default 60, death pause; OVER_FRAMES default 180, game-over screen; START_LIVES default 3, lives at game start.
REQ-002 clk  in  1  pixel clock, the single clock domain.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start_btn  in  1  raw start button, asynchronous.
REQ-005 vsync  in  1  vertical sync from the timing chain; its rising edge marks the frame tick.
REQ-006 player_hit  in  1  level-sensitive collision flag from the gameplay logic.
REQ-007 player_win  in  1  level-sensitive flag, player reached the goal.
REQ-008 start_game  out  1  enables the ladder, platform and sprite draw stages.
REQ-009 freeze  out  1  halts movement logic while high.
REQ-010 level  out  2  current level index, 0..3.
REQ-011 lives  out  2  remaining lives.
REQ-012 show_title, show_over  out  1 each  overlay selects for the title and game-over screens.

Function
REQ-013 start_btn SHALL pass through a 2-FF synchronizer; a press SHALL be the rising edge of the synchronized value.
REQ-014 frame_tick SHALL be a one-cycle pulse, registered one cycle after a vsync rising edge is detected.
REQ-015 The FSM SHALL have exactly these states: TITLE, INTRO, PLAY, CLEAR, DEATH, OVER.
REQ-016 TITLE->INTRO on a press; on this transition level:=0 and lives:=START_LIVES.
REQ-017 In INTRO, frame_cnt (8 bit) SHALL increment on each frame_tick; on the tick where frame_cnt==INTRO_FRAMES-1 the FSM SHALL go to PLAY.
REQ-018 PLAY->DEATH when player_hit=1; PLAY->CLEAR when player_win=1 and player_hit=0 (hit has priority when both are high).
REQ-019 CLEAR: after CLEAR_FRAMES ticks, if level==3 go to TITLE, else level:=level+1 and go to INTRO. level SHALL never wrap.
REQ-020 DEATH: after DEATH_FRAMES ticks, if lives==1 then lives:=0 and go to OVER, else lives:=lives-1 and go to INTRO (level unchanged).
REQ-021 OVER: after OVER_FRAMES ticks, go to TITLE; presses in OVER SHALL be ignored.
REQ-022 frame_cnt SHALL clear to 0 in the cycle any state transition occurs.
REQ-023 Presses outside TITLE SHALL be ignored. player_hit and player_win SHALL be ignored outside PLAY.
REQ-024 All outputs SHALL be registered and SHALL reflect a new state one cycle after the transition cycle.
REQ-025 Output decode:
- start_game=1 in INTRO, PLAY, CLEAR, DEATH.
- freeze=1 in every state except PLAY.
- show_title=1 only in TITLE.
- show_over=1 only in OVER.
REQ-026 A transition condition and a frame_tick in the same cycle SHALL be evaluated together; the state change takes effect at the next edge.

Reset
REQ-027 On rst=1, asynchronously: state=TITLE, frame_cnt=0, level=0, lives=0, start_game=0, freeze=1, show_title=1, show_over=0, synchronizer and edge-detect flops=0.
REQ-028 Reset asserted mid-game SHALL abort to TITLE with no partial update of level or lives.

Structure
REQ-029 The state enum type and the default frame constants SHALL live in vgaPkg.
REQ-030 The synchronizer plus edge detector SHALL be one sub-module, btn_edge. Frame-tick detection stays inline.

Verification
REQ-031 Reset, then one press, then 120 vsync pulses -> start_game=1 from the cycle after the press; freeze falls after the 120th tick; level=0, lives=3.
REQ-032 In PLAY, player_hit and player_win high in the same cycle -> DEATH; after 60 ticks, INTRO with lives=2 and level unchanged.
REQ-033 Three deaths from lives=3 -> OVER with lives=0 and show_over=1; after 180 ticks, TITLE; a press during OVER has no effect.
REQ-034 Win on levels 0, 1, 2 -> level increments 1, 2, 3; a win on level 3 -> TITLE after 90 ticks with level held at 3.
REQ-035 rst asserted in CLEAR at frame_cnt=45 -> all outputs match the REQ-027 values immediately, with no level increment.
REQ-036 A press held for many cycles in TITLE -> exactly one transition; player_win pulsed in TITLE or INTRO -> ignored.
